// File: rtl/ula_pkg.sv
// Shared ULA datapath types and helpers.
package ula_pkg;

  localparam int unsigned UlaWidth = 4;

  typedef enum logic [1:0] {StIdle, StCalc, StFinish} div_state_e;

  // Bits needed to hold an iteration count of 0..width.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract the divisor.
module div_step #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             quot_o
);

  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] sub_b;
  logic [WIDTH-1:0] diff;
  logic [WIDTH:0]   carry;

  assign shifted  = {rem_i[WIDTH-2:0], bit_i};
  assign sub_b    = ~divisor_i;
  assign carry[0] = 1'b1;

  // Ripple of full adders computing shifted + ~divisor + 1.
  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign diff[i]    = shifted[i] ^ sub_b[i] ^ carry[i];
    assign carry[i+1] = (shifted[i] & sub_b[i]) | (carry[i] & (shifted[i] ^ sub_b[i]));
  end

  // Top stage adds the shifted-out MSB to an all-ones divisor extension: carry = msb | carry.
  assign quot_o = rem_i[WIDTH-1] | carry[WIDTH];
  assign rem_o  = quot_o ? diff : shifted;

endmodule

// File: rtl/div4bit_seq.sv
// Sequential restoring divider: one quotient bit per clock, start/busy/done handshake.
module div4bit_seq
  import ula_pkg::*;
#(
  parameter int unsigned WIDTH = UlaWidth
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             DivZero
);

  localparam int unsigned    CntW        = cnt_width(WIDTH);
  localparam logic [WIDTH-1:0] DivZeroQuot = '1;

  div_state_e       state_q;
  logic [CntW-1:0]  cnt_q;
  logic [WIDTH-1:0] dividend_q;
  logic [WIDTH-1:0] divisor_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quot_q;
  logic [WIDTH-1:0] rem_out_q;
  logic             div_zero_q;
  logic             busy_q;
  logic             done_q;

  logic [WIDTH-1:0] step_rem;
  logic             step_quot;

  div_step #(
    .WIDTH(WIDTH)
  ) u_div_step (
    .rem_i    (rem_q),
    .bit_i    (dividend_q[WIDTH-1]),
    .divisor_i(divisor_q),
    .rem_o    (step_rem),
    .quot_o   (step_quot)
  );

  // The dividend register doubles as the quotient shift register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
      rem_q      <= '0;
      quot_q     <= '0;
      rem_out_q  <= '0;
      div_zero_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle, StFinish: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          if (start) begin
            if (B != '0) begin
              dividend_q <= A;
              divisor_q  <= B;
              rem_q      <= '0;
              cnt_q      <= CntW'(WIDTH);
              busy_q     <= 1'b1;
              state_q    <= StCalc;
            end else begin
              quot_q     <= DivZeroQuot;
              rem_out_q  <= A;
              div_zero_q <= 1'b1;
              done_q     <= 1'b1;
              state_q    <= StFinish;
            end
          end
        end
        StCalc: begin
          rem_q      <= step_rem;
          dividend_q <= {dividend_q[WIDTH-2:0], step_quot};
          cnt_q      <= cnt_q - 1'b1;
          // Last iteration publishes results directly so done follows immediately.
          if (cnt_q == CntW'(1)) begin
            quot_q     <= {dividend_q[WIDTH-2:0], step_quot};
            rem_out_q  <= step_rem;
            div_zero_q <= 1'b0;
            done_q     <= 1'b1;
            busy_q     <= 1'b0;
            state_q    <= StFinish;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign Quotient  = quot_q;
  assign Remainder = rem_out_q;
  assign DivZero   = div_zero_q;

endmodule
